// File: rtl/rom_reader.sv
// Command-driven ROM read initiator: issues `len` consecutive addresses with a
// bounded number in flight and forwards returned words as a stream with last/done.
module rom_reader #(
    parameter int W_DATA  = 13,
    parameter int W_ADDR  = 12,
    parameter int MAX_OUT = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [W_ADDR-1:0]        cmd_base,
    input  logic [W_ADDR:0]          cmd_len,
    output logic                     addr1_valid,
    input  logic                     addr1_ready,
    output logic [W_ADDR-1:0]        addr1_data,
    input  logic                     data1_valid,
    output logic                     data1_ready,
    input  logic signed [W_DATA-1:0] data1,
    output logic                     dout_valid,
    input  logic                     dout_ready,
    output logic signed [W_DATA-1:0] dout_data,
    output logic                     dout_last,
    output logic                     done
);
    localparam int              W_OUT   = $clog2(MAX_OUT + 1);
    localparam logic [W_OUT-1:0] OUT_MAX = W_OUT'(MAX_OUT);
    localparam logic [W_ADDR:0]  CNT_ONE = (W_ADDR + 1)'(1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN} state_t;

    state_t              r_state;
    logic [W_ADDR:0]     r_len;
    logic [W_ADDR:0]     r_issue_cnt;
    logic [W_ADDR:0]     r_recv_cnt;
    logic [W_ADDR-1:0]   r_addr_ptr;
    logic [W_OUT-1:0]    r_outstanding;
    logic                r_done;

    logic w_busy;
    logic w_cmd_hs;
    logic w_addr_hs;
    logic w_data_hs;
    logic w_last;

    // Returned words only flow while a command is active, so outstanding never underflows.
    assign w_busy      = (r_state != S_IDLE);
    assign cmd_ready   = !w_busy;
    assign addr1_valid = (r_state == S_ISSUE) && (r_outstanding < OUT_MAX);
    assign addr1_data  = r_addr_ptr;
    assign dout_valid  = data1_valid & w_busy;
    assign dout_data   = data1;
    assign data1_ready = dout_ready & w_busy;
    assign w_last      = (r_recv_cnt == (r_len - CNT_ONE));
    assign dout_last   = dout_valid & w_last;
    assign done        = r_done;

    assign w_cmd_hs  = cmd_valid & cmd_ready;
    assign w_addr_hs = addr1_valid & addr1_ready;
    assign w_data_hs = dout_valid & dout_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_len         <= '0;
            r_issue_cnt   <= '0;
            r_recv_cnt    <= '0;
            r_addr_ptr    <= '0;
            r_outstanding <= '0;
            r_done        <= 1'b0;
        end else begin
            r_done <= 1'b0;

            if (w_addr_hs && !w_data_hs) begin
                r_outstanding <= r_outstanding + 1'b1;
            end else if (!w_addr_hs && w_data_hs) begin
                r_outstanding <= r_outstanding - 1'b1;
            end

            if (w_addr_hs) begin
                r_addr_ptr  <= r_addr_ptr + 1'b1;
                r_issue_cnt <= r_issue_cnt + CNT_ONE;
            end
            if (w_data_hs) begin
                r_recv_cnt <= r_recv_cnt + CNT_ONE;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_cmd_hs) begin
                        r_len         <= cmd_len;
                        r_addr_ptr    <= cmd_base;
                        r_issue_cnt   <= '0;
                        r_recv_cnt    <= '0;
                        r_outstanding <= '0;
                        if (cmd_len == '0) begin
                            r_done <= 1'b1;
                        end else begin
                            r_state <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    if (w_addr_hs && ((r_issue_cnt + CNT_ONE) == r_len)) begin
                        r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase

            // The last word can only be delivered after every address has been issued.
            if (w_data_hs && w_last) begin
                r_state <= S_IDLE;
                r_done  <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_rom_reader.sv
// Self-checking bench for rom_reader: an in-bench ROM responder with programmable
// latency plus a queue-based model of the expected address and word streams.
module tb_rom_reader;
    logic               clk = 1'b0;
    logic               rst;
    logic               cmd_valid;
    logic               cmd_ready;
    logic [11:0]        cmd_base;
    logic [12:0]        cmd_len;
    logic               addr1_valid;
    logic               addr1_ready;
    logic [11:0]        addr1_data;
    logic               data1_valid;
    logic               data1_ready;
    logic signed [12:0] data1;
    logic               dout_valid;
    logic               dout_ready;
    logic signed [12:0] dout_data;
    logic               dout_last;
    logic               done;

    rom_reader #(.W_DATA(13), .W_ADDR(12), .MAX_OUT(4)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_base(cmd_base), .cmd_len(cmd_len),
        .addr1_valid(addr1_valid), .addr1_ready(addr1_ready), .addr1_data(addr1_data),
        .data1_valid(data1_valid), .data1_ready(data1_ready), .data1(data1),
        .dout_valid(dout_valid), .dout_ready(dout_ready), .dout_data(dout_data),
        .dout_last(dout_last), .done(done)
    );

    always #5 clk = ~clk;

    logic signed [12:0] rom [4096];

    int n_checks = 0;
    int n_err    = 0;

    // Responder state: accepted addresses and the cycle each was accepted.
    logic [11:0] pend_a[$];
    int          pend_t[$];
    // Reference: addresses still to be issued and words still to be delivered.
    logic [11:0] exp_addr[$];
    logic [11:0] exp_words[$];
    logic busy_m  = 1'b0;
    logic done_exp = 1'b0;
    int   outst_m = 0;
    int   a_cnt   = 0;
    logic seen_data = 1'b0;
    int   cyc = 0;
    int   rel = 0;
    int   lat = 1;
    int   ar_pct = 100;
    int   dr_pct = 100;
    int   low_start = 1000;
    int   low_len   = 0;
    int   words_out = 0;

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic reset_model();
        pend_a.delete();
        pend_t.delete();
        exp_addr.delete();
        exp_words.delete();
        busy_m    = 1'b0;
        done_exp  = 1'b0;
        outst_m   = 0;
    endtask

    // One clock cycle: drive at the falling edge, check 1 ns later, update the model after the rising edge.
    task automatic cycle();
        logic a_hs, d_hs, c_hs, r_now, exp_av, exp_last;
        logic [11:0] a_addr;
        logic [12:0] c_len;
        logic [11:0] c_base;
        addr1_ready = ($urandom_range(99) < ar_pct);
        if ((rel >= low_start) && (rel < low_start + low_len)) dout_ready = 1'b0;
        else dout_ready = ($urandom_range(99) < dr_pct);
        if (pend_a.size() > 0 && (cyc - pend_t[0]) >= lat) begin
            data1_valid = 1'b1;
            data1       = rom[pend_a[0]];
        end else begin
            data1_valid = 1'b0;
            data1       = 13'($urandom);
        end
        #1;
        r_now    = rst;
        exp_av   = busy_m && (exp_addr.size() > 0) && (outst_m < 4);
        exp_last = (exp_words.size() == 1);
        chk("done", done, done_exp);
        chk("cmd_ready", cmd_ready, !busy_m);
        chk("addr1_valid", addr1_valid, exp_av);
        chk("dout_valid", dout_valid, busy_m && data1_valid);
        chk("data1_ready", data1_ready, busy_m && dout_ready);
        chk("dout_last", dout_last, dout_valid && exp_last);
        a_hs   = addr1_valid & addr1_ready;
        d_hs   = dout_valid & dout_ready;
        c_hs   = cmd_valid & cmd_ready;
        a_addr = addr1_data;
        c_len  = cmd_len;
        c_base = cmd_base;
        if (a_hs && exp_addr.size() > 0) chk("addr1_data", addr1_data, exp_addr[0]);
        if (d_hs && exp_words.size() > 0) begin
            chk("dout_data", dout_data, rom[exp_words[0]]);
            if (!seen_data) chk("addr_before_data", a_cnt <= 4, 1);
        end
        @(posedge clk);
        cyc++;
        rel++;
        if (r_now) begin
            reset_model();
        end else begin
            done_exp = 1'b0;
            if (c_hs) begin
                if (c_len == 0) done_exp = 1'b1;
                else begin
                    busy_m = 1'b1;
                    for (int i = 0; i < int'(c_len); i++) begin
                        exp_addr.push_back(12'(int'(c_base) + i));
                        exp_words.push_back(12'(int'(c_base) + i));
                    end
                end
                a_cnt = 0;
                seen_data = 1'b0;
                rel = 0;
            end
            if (a_hs) begin
                pend_a.push_back(a_addr);
                pend_t.push_back(cyc);
                if (exp_addr.size() > 0) void'(exp_addr.pop_front());
                outst_m++;
                a_cnt++;
            end
            if (d_hs) begin
                void'(pend_a.pop_front());
                void'(pend_t.pop_front());
                outst_m--;
                seen_data = 1'b1;
                words_out++;
                if (exp_words.size() == 1) begin
                    busy_m   = 1'b0;
                    done_exp = 1'b1;
                end
                if (exp_words.size() > 0) void'(exp_words.pop_front());
            end
            chk("outstanding_bound", (outst_m >= 0) && (outst_m <= 4), 1);
        end
        @(negedge clk);
    endtask

    task automatic run_cmd(input int b, input int l, input int ls, input int ll);
        int guard;
        guard     = 0;
        low_start = ls;
        low_len   = ll;
        words_out = 0;
        cmd_valid = 1'b1;
        cmd_base  = 12'(b);
        cmd_len   = 13'(l);
        cycle();
        cmd_valid = 1'b0;
        cmd_base  = 12'($urandom);
        cmd_len   = 13'($urandom);
        while (busy_m && guard < 400) begin
            cycle();
            guard++;
        end
        chk("cmd_timeout", guard < 400, 1);
        chk("word_count", words_out, l);
        $display("cmd base=0x%03h len=%0d lat=%0d words=%0d errors=%0d", b, l, lat, words_out, n_err);
        low_len = 0;
    endtask

    initial begin
        int guard;
        for (int i = 0; i < 4096; i++) rom[i] = 13'($urandom);
        rom[12'h010] = 13'sd5;
        rom[12'h011] = -13'sd7;
        rom[12'h012] = 13'sd100;

        rst = 1'b1; cmd_valid = 1'b0; cmd_base = '0; cmd_len = '0;
        addr1_ready = 1'b0; data1_valid = 1'b0; data1 = '0; dout_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        dout_ready = 1'b1; data1_valid = 1'b1; data1 = 13'sd9;
        #1;
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_addr1_valid", addr1_valid, 0);
        chk("rst_data1_ready", data1_ready, 0);
        chk("rst_dout_valid", dout_valid, 0);
        chk("rst_dout_last", dout_last, 0);
        chk("rst_done", done, 0);
        chk("rst_addr1_data", addr1_data, 0);
        @(negedge clk);
        rst = 1'b0;
        reset_model();
        cycle();

        // Directed: basic read, empty command, address wrap.
        lat = 1; ar_pct = 100; dr_pct = 100;
        run_cmd(12'h010, 3, 1000, 0);
        run_cmd(12'h055, 0, 1000, 0);
        run_cmd(12'hFFE, 4, 1000, 0);

        // Sink stalls for 10 cycles mid-command; outstanding must saturate at 4.
        lat = 2;
        run_cmd(12'h200, 8, 2, 10);
        lat = 6;
        run_cmd(12'h300, 12, 1000, 0);

        // Reset with two requests in flight, then a fresh command.
        lat = 8;
        cmd_valid = 1'b1; cmd_base = 12'h100; cmd_len = 13'd8;
        cycle();
        cmd_valid = 1'b0;
        guard = 0;
        while (outst_m != 2 && guard < 50) begin
            cycle();
            guard++;
        end
        chk("reach_outst2", outst_m, 2);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        cycle();
        lat = 1;
        run_cmd(12'h020, 2, 1000, 0);

        // Randomised commands with random readiness and latency.
        for (int k = 0; k < 20; k++) begin
            lat    = $urandom_range(1, 6);
            ar_pct = $urandom_range(30, 100);
            dr_pct = $urandom_range(30, 100);
            run_cmd(int'($urandom_range(0, 4095)), int'($urandom_range(0, 20)), 1000, 0);
        end
        ar_pct = 100; dr_pct = 100;
        cycle();
        cycle();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
